simon_host_ctrl: RTL and testbench

- Host-side initiator for the SIMON_9696 core handshake (newData/loadData/doneData/readData, newKey/loadKey).
- Accepts keys and 2N-bit blocks from a valid/ready stream and drives the core one block at a time.
- Captures each result into a DEPTH-entry output FIFO.
- Presents results on a valid/ready output stream.
- Sits between the system bus/stream logic and the cipher core, replacing bench-driven sequencing with synthesizable RTL.

---
 rtl/simon_host_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_simon_host_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_host_ctrl.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module      : simon_host_ctrl
//  Description : Host-side initiator for the SIMON_9696 core handshake.
//                Takes keys and blocks from valid/ready streams and drives
//                the core through its four-phase handshake, one block at a
//                time. Each result goes into a DEPTH-entry FIFO, which is
//                presented on a valid/ready output stream.
//  Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module simon_host_ctrl #(
   parameter int N     = 48,
   parameter int M     = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             R,
   // key stream
   input  logic             key_valid,
   input  logic [M*N-1:0]   key_in,
   output logic             key_ready,
   // block input stream
   input  logic             in_valid,
   input  logic [2*N-1:0]   in_block,
   input  logic             in_enc_dec,
   output logic             in_ready,
   // result output stream
   output logic             out_valid,
   output logic [2*N-1:0]   out_block,
   input  logic             out_ready,
   // core handshake
   output logic             newData,
   output logic             newKey,
   output logic             enc_dec,
   output logic             readData,
   output logic [2*N-1:0]   inData,
   output logic [M*N-1:0]   key,
   input  logic             loadData,
   input  logic             loadKey,
   input  logic             doneData,
   input  logic [2*N-1:0]   outData,
   output logic             busy
);

   localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CW = $clog2(DEPTH + 1);
   localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
   localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
   localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(DEPTH);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RUN     = 3'd2,
      READ    = 3'd3,
      RELEASE = 3'd4
   } dataState_t;

   typedef enum logic [0:0] {
      KIDLE = 1'b0,
      KLOAD = 1'b1
   } keyState_t;

   dataState_t r_state, w_stateNext;
   keyState_t  r_kState, w_kStateNext;

   logic                 r_keyLoaded;
   logic                 w_keyAccept;
   logic                 w_blkAccept;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;

   logic [2*N-1:0]       r_mem [DEPTH];
   logic [c_PW-1:0]      r_wrPtr;
   logic [c_PW-1:0]      r_rdPtr;
   logic [c_PW-1:0]      w_rdNext;
   logic [c_CW-1:0]      r_count;

   // Stream handshakes; a pending key blocks block acceptance in the same cycle
   assign key_ready   = (r_kState == KIDLE) && (r_state == IDLE);
   assign in_ready    = (r_state == IDLE) && (r_kState == KIDLE) && r_keyLoaded && !key_valid;
   assign w_keyAccept = key_valid && key_ready;
   assign w_blkAccept = in_valid && in_ready;

   // FIFO status; a pop in the same cycle frees room for the push
   assign out_valid = (r_count != '0);
   assign w_full    = (r_count == c_CNT_FULL);
   assign w_pop     = out_valid && out_ready;
   assign w_push    = (r_state == RUN) && doneData && (!w_full || w_pop);
   assign w_rdNext  = r_rdPtr + c_PTR_ONE;

   assign busy = (r_state != IDLE) || (r_kState != KIDLE);

   // Key FSM state register
   always_ff @(posedge clk) begin
      if (R) r_kState <= KIDLE;
      else   r_kState <= w_kStateNext;
   end

   // Key FSM next state; newKey is held for the whole KLOAD phase
   always_comb begin
      w_kStateNext = r_kState;
      newKey       = 1'b0;
      case (r_kState)
         KIDLE: begin
            if (w_keyAccept) w_kStateNext = KLOAD;
         end
         KLOAD: begin
            newKey = 1'b1;
            if (loadKey) w_kStateNext = KIDLE;
         end
         default: w_kStateNext = KIDLE;
      endcase
   end

   // Data FSM state register
   always_ff @(posedge clk) begin
      if (R) r_state <= IDLE;
      else   r_state <= w_stateNext;
   end

   // Data FSM next state; readData covers READ and RELEASE so it drops on return to IDLE
   always_comb begin
      w_stateNext = r_state;
      newData     = 1'b0;
      readData    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_blkAccept) w_stateNext = LOAD;
         end
         LOAD: begin
            newData = 1'b1;
            if (loadData) w_stateNext = RUN;
         end
         RUN: begin
            if (w_push) w_stateNext = READ;
         end
         READ: begin
            readData = 1'b1;
            if (!doneData) w_stateNext = RELEASE;
         end
         RELEASE: begin
            readData    = 1'b1;
            w_stateNext = IDLE;
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Key and block holding registers; values stay stable for the whole handshake
   always_ff @(posedge clk) begin
      if (R) begin
         key         <= '0;
         inData      <= '0;
         enc_dec     <= 1'b0;
         r_keyLoaded <= 1'b0;
      end else begin
         if (w_keyAccept) begin
            key         <= key_in;
            r_keyLoaded <= 1'b0;
         end else if ((r_kState == KLOAD) && loadKey) begin
            r_keyLoaded <= 1'b1;
         end
         if (w_blkAccept) begin
            inData  <= in_block;
            enc_dec <= in_enc_dec;
         end
      end
   end

   // FIFO storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr] <= outData;
   end

   // FIFO pointers, occupancy and registered head
   always_ff @(posedge clk) begin
      if (R) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         out_block <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + c_PTR_ONE;
         if (w_pop)  r_rdPtr <= w_rdNext;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         // A push into a FIFO that is (or becomes) empty bypasses the array
         if (w_push && ((r_count == '0) || (w_pop && (r_count == c_CNT_ONE))))
            out_block <= outData;
         else if (w_pop)
            out_block <= r_mem[w_rdNext];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_simon_host_ctrl.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module      : tb_simon_host_ctrl
//  Description : Directed self-checking bench for simon_host_ctrl with a
//                behavioural stand-in for the SIMON_9696 core handshake.
//  Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_simon_host_ctrl;

   localparam int N     = 48;
   localparam int M     = 2;
   localparam int DEPTH = 4;
   localparam int LAT   = 3;

   localparam logic [95:0] c_KEY0 = 96'h0D0C0B0A0908_050403020100;
   localparam logic [95:0] c_PT   = 96'h2072616C6C69702065687420;
   localparam logic [95:0] c_CT   = 96'h602807A462B469063D8FF082;

   logic           clk        = 1'b0;
   logic           R          = 1'b1;
   logic           key_valid  = 1'b0;
   logic [95:0]    key_in     = '0;
   logic           key_ready;
   logic           in_valid   = 1'b0;
   logic [95:0]    in_block   = '0;
   logic           in_enc_dec = 1'b0;
   logic           in_ready;
   logic           out_valid;
   logic [95:0]    out_block;
   logic           out_ready  = 1'b0;
   logic           newData, newKey, enc_dec, readData, busy;
   logic [95:0]    inData;
   logic [95:0]    key;
   logic           loadData   = 1'b0;
   logic           loadKey    = 1'b0;
   logic           doneData   = 1'b0;
   logic [95:0]    outData    = '0;

   int checks = 0;
   int errors = 0;

   simon_host_ctrl #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
      .clk(clk), .R(R),
      .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
      .in_valid(in_valid), .in_block(in_block), .in_enc_dec(in_enc_dec), .in_ready(in_ready),
      .out_valid(out_valid), .out_block(out_block), .out_ready(out_ready),
      .newData(newData), .newKey(newKey), .enc_dec(enc_dec), .readData(readData),
      .inData(inData), .key(key),
      .loadData(loadData), .loadKey(loadKey), .doneData(doneData), .outData(outData),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Stand-in cipher: the published test vector under the reference key, a reversible scramble otherwise
   function automatic logic [95:0] core_f(input logic [95:0] d, input logic e, input logic [95:0] k);
      logic [95:0] t;
      if (k == c_KEY0 && e && d == c_PT)  return c_CT;
      if (k == c_KEY0 && !e && d == c_CT) return c_PT;
      if (e) begin
         t = {d[94:0], d[95]};
         return t ^ k;
      end
      t = d ^ k;
      return {t[0], t[95:1]};
   endfunction

   function automatic logic [95:0] blk(input int i);
      return 96'h0123456789ABCDEF00112233 + 96'(i) * 96'h000001000001000001;
   endfunction

   // Core model: four-phase key and data handshakes, driven on the falling edge
   int          kc  = 0;
   int          dc  = 0;
   int          cph = 0;
   logic [95:0] cIn  = '0;
   logic [95:0] cKey = '0;
   logic        cEnc = 1'b0;
   bit          sawLoadKey = 1'b0;

   always @(negedge clk) begin
      if (R) begin
         loadKey = 1'b0; loadData = 1'b0; doneData = 1'b0; outData = '0;
         cph = 0; kc = 0; dc = 0;
      end else begin
         if (newKey && !loadKey) begin
            kc++;
            if (kc >= 2) begin
               loadKey = 1'b1; cKey = key; sawLoadKey = 1'b1;
            end
         end else if (!newKey) begin
            loadKey = 1'b0; kc = 0;
         end
         case (cph)
            0: if (newData && !loadData) begin
                  cIn = inData; cEnc = enc_dec; loadData = 1'b1; cph = 1;
               end
            1: if (!newData) begin
                  loadData = 1'b0; dc = LAT; cph = 2;
               end
            2: begin
                  dc--;
                  if (dc == 0) begin
                     outData = core_f(cIn, cEnc, cKey); doneData = 1'b1; cph = 3;
                  end
               end
            3: if (readData) begin
                  doneData = 1'b0; cph = 4;
               end
            4: if (!readData) cph = 0;
            default: cph = 0;
         endcase
      end
   end

   task automatic load_key(input logic [95:0] k);
      int n;
      key_valid = 1'b1; key_in = k; sawLoadKey = 1'b0;
      n = 0;
      while (!key_ready && n < 200) begin step(); n++; end
      check("key_ready_wait", key_ready, 1);
      step();
      key_valid = 1'b0;
      check("newKey_rise", newKey, 1);
      check("key_latched", key, k);
      n = 0;
      while (newKey && n < 50) begin step(); n++; end
      check("newKey_fall", newKey, 0);
      check("loadKey_before_fall", sawLoadKey, 1);
   endtask

   task automatic send_block(input logic [95:0] b, input logic e);
      int n;
      in_valid = 1'b1; in_block = b; in_enc_dec = e;
      n = 0;
      while (!in_ready && n < 300) begin step(); n++; end
      check("in_ready_wait", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("newData_rise", newData, 1);
      check("inData_latched", inData, b);
      check("enc_dec_latched", enc_dec, e);
   endtask

   task automatic pop_expect(input string tag, input logic [95:0] exp);
      int n;
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 300) begin step(); n++; end
      check({tag, "_valid"}, out_valid, 1);
      check(tag, out_block, exp);
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      int n;
      R = 1'b1;
      repeat (2) step();
      R = 1'b0;

      // Reset state
      check("rst_key_ready", key_ready, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_block", out_block, 0);
      check("rst_newData", newData, 0);
      check("rst_newKey", newKey, 0);
      check("rst_readData", readData, 0);
      check("rst_busy", busy, 0);
      check("rst_key", key, 0);

      // Block offered before any key is loaded
      in_valid = 1'b1; in_block = c_PT; in_enc_dec = 1'b1;
      repeat (4) begin
         step();
         check("nokey_in_ready", in_ready, 0);
         check("nokey_newData", newData, 0);
      end

      // Key and block offered together: key wins
      key_valid = 1'b1; key_in = c_KEY0; sawLoadKey = 1'b0;
      #1;
      check("both_key_ready", key_ready, 1);
      check("both_in_ready", in_ready, 0);
      step();
      key_valid = 1'b0; in_valid = 1'b0;
      check("both_newKey", newKey, 1);
      check("both_newData", newData, 0);
      check("both_busy", busy, 1);
      n = 0;
      while (newKey && n < 50) begin step(); n++; end
      check("both_newKey_fall", newKey, 0);
      check("both_loadKey_seen", sawLoadKey, 1);
      check("both_key", key, c_KEY0);
      check("keyed_in_ready", in_ready, 1);

      // Encrypt and decrypt the reference vector
      send_block(c_PT, 1'b1);
      pop_expect("enc_out", c_CT);
      send_block(c_CT, 1'b0);
      pop_expect("dec_out", c_PT);

      // Five blocks with the output stalled: four stored, fifth waits in RUN
      for (int i = 0; i < 5; i++) send_block(blk(i), 1'b1);
      repeat (20) step();
      check("stall_readData", readData, 0);
      check("stall_in_ready", in_ready, 0);
      check("stall_busy", busy, 1);
      check("stall_out_valid", out_valid, 1);
      check("stall_doneData", doneData, 1);
      check("stall_head", out_block, core_f(blk(0), 1'b1, c_KEY0));
      for (int i = 0; i < 5; i++) pop_expect("stall_out", core_f(blk(i), 1'b1, c_KEY0));

      // Full FIFO with simultaneous pop and push, pointers now wrapped
      for (int i = 5; i < 10; i++) send_block(blk(i), 1'b1);
      repeat (20) step();
      check("full_readData", readData, 0);
      out_ready = 1'b1;
      #1;
      check("full_head", out_block, core_f(blk(5), 1'b1, c_KEY0));
      step();
      out_ready = 1'b0;
      check("pp_readData", readData, 1);
      check("pp_head", out_block, core_f(blk(6), 1'b1, c_KEY0));
      send_block(blk(10), 1'b1);
      repeat (20) step();
      check("pp_full_again", readData, 0);
      for (int i = 6; i < 11; i++) pop_expect("wrap_out", core_f(blk(i), 1'b1, c_KEY0));

      // Reset while in READ
      send_block(blk(11), 1'b1);
      n = 0;
      while (!readData && n < 100) begin step(); n++; end
      check("pre_rst_readData", readData, 1);
      R = 1'b1;
      step();
      check("mid_rst_readData", readData, 0);
      check("mid_rst_newData", newData, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_key_ready", key_ready, 1);
      check("mid_rst_in_ready", in_ready, 0);
      R = 1'b0;
      in_valid = 1'b1; in_block = blk(12); in_enc_dec = 1'b1;
      repeat (3) begin
         step();
         check("post_rst_in_ready", in_ready, 0);
         check("post_rst_newData", newData, 0);
      end
      in_valid = 1'b0;
      load_key(c_KEY0);
      check("rekey_in_ready", in_ready, 1);
      send_block(c_PT, 1'b1);
      pop_expect("rekey_enc_out", c_CT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
